// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for seq_divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  localparam int DIV_W_DEFAULT = 32;

  // Fill bit for the divide-by-zero quotient, replicated to the operand width (all ones).
  localparam logic DIV_DZ_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on {R,Q} against D
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_W_DEFAULT
) (
  input  logic [N:0]   r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic [N-1:0] q_next
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;

  // R stays below D between steps, so the shifted value never needs more than N+1 bits
  // and the extra top bit of trial is a clean borrow flag.
  always_comb begin
    shifted = {r, q[N-1]};
    trial   = shifted - {2'b00, d};
    if (trial[N+1]) begin
      r_next = shifted[N:0];
      q_next = {q[N-2:0], 1'b0};
    end else begin
      r_next = trial[N:0];
      q_next = {q[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring unsigned divider, one quotient bit per enabled cycle
// Optional DIV_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  div_state_t    state_q, state_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dzo_q, dzo_d;

  logic [N:0]    step_r;
  logic [N-1:0]  step_q;

  div_step #(.N(N)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (d_q),
    .r_next (step_r),
    .q_next (step_q)
  );

  // Shortcut paths preload R and Q with the final answer so FINISH is a plain transfer.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = CNT_INIT;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = CALC;
          if (divisor == '0) begin
            q_d     = {N{DIV_DZ_FILL}};
            r_d     = {1'b0, dividend};
            dz_d    = 1'b1;
            state_d = FINISH;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (dividend < divisor) begin
            q_d     = '0;
            r_d     = {1'b0, dividend};
            state_d = FINISH;
          end
`endif
        end
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        quot_d  = q_q;
        rem_d   = r_q[N-1:0];
        dzo_d   = dz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider at N=32 and N=8
module tb_seq_divider;

  typedef longint unsigned u64;
  typedef struct {
    u64 a;
    u64 b;
    u64 q;
    u64 r;
    bit dz;
    int acc;
    int lat;
  } exp_t;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  logic        en8 = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  dividend8 = '0;
  logic [7:0]  divisor8 = '0;
  logic        busy8, done8, div_by_zero8;
  logic [7:0]  quotient8, remainder8;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev32 = 1'b0;
  logic prev8 = 1'b0;
  exp_t sb32[$];
  exp_t sb8[$];

  seq_divider #(.N(32)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  seq_divider #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .en(en8), .start(start8),
    .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8),
    .remainder(remainder8), .div_by_zero(div_by_zero8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input u64 act, input u64 exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=done_pulse expected=no_pending_operation", name);
  endtask

  // Reference: plain integer division, with the divide-by-zero and short-latency rules.
  function automatic exp_t model(input u64 a, input u64 b, input int w, input int stall);
    exp_t e;
    e.a = a;
    e.b = b;
    e.acc = 0;
    if (b == 0) begin
      e.q   = (u64'(1) << w) - 1;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dz  = 1'b0;
      e.lat = (EARLY && a < b) ? 1 : w + 1;
    end
    e.lat += stall;
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input u64 q, input u64 r,
                       input bit dz, input bit bz);
    chk({tag, "_quotient"}, q, e.q);
    chk({tag, "_remainder"}, r, e.r);
    chk({tag, "_div_by_zero"}, u64'(dz), u64'(e.dz));
    chk({tag, "_latency"}, u64'(cyc - e.acc), u64'(e.lat));
    chk({tag, "_busy_with_done"}, u64'(bz), 0);
    if (!e.dz) begin
      chk({tag, "_invariant"}, q * e.b + r, e.a);
      chk({tag, "_rem_lt_div"}, u64'(r < e.b), 1);
    end
  endtask

  initial begin : mon32
    forever begin
      @(negedge clk);
      if (done && !prev32) begin
        if (sb32.size() == 0) unexpected("done32");
        else score("n32", sb32.pop_front(), quotient, remainder, div_by_zero, busy);
      end
      prev32 = done;
    end
  end

  initial begin : mon8
    forever begin
      @(negedge clk);
      if (done8 && !prev8) begin
        if (sb8.size() == 0) unexpected("done8");
        else score("n8", sb8.pop_front(), quotient8, remainder8, div_by_zero8, busy8);
      end
      prev8 = done8;
    end
  end

  // Caller guarantees the selected DUT is in IDLE this cycle; returns in the cycle done is high.
  task automatic issue(input bit w8, input u64 a, input u64 b, input int stall, input bit poke);
    exp_t e;
    int   n;
    e = model(a, b, w8 ? 8 : 32, stall);
    if (w8) begin
      dividend8 = a[7:0];
      divisor8  = b[7:0];
      start8    = 1'b1;
    end else begin
      dividend = a[31:0];
      divisor  = b[31:0];
      start    = 1'b1;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    start8 = 1'b0;
    e.acc  = cyc;
    if (w8) sb8.push_back(e);
    else sb32.push_back(e);
    chk(w8 ? "busy8_accept" : "busy32_accept", w8 ? busy8 : busy, 1);
    if (stall > 0) begin
      repeat (9) @(posedge clk);
      #1 en = 1'b0;
      repeat (stall) @(posedge clk);
      #1 en = 1'b1;
    end
    if (poke) begin
      dividend = 32'd7;
      divisor  = 32'd2;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    n = 0;
    while (!(w8 ? done8 : done) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(w8 ? "done8_timeout" : "done32_timeout", w8 ? done8 : done, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    u64 a, b;
    int sel;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_div_by_zero", div_by_zero, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 100, 7, 0, 1'b0);
    issue(1'b0, 64'hFFFF_FFFF, 1, 0, 1'b0);
    issue(1'b0, 5, 0, 0, 1'b0);
    issue(1'b0, 3, 10, 0, 1'b0);
    issue(1'b0, 1000, 3, 5, 1'b1);

    // Abandon 50/5 mid-calculation with an asynchronous reset.
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_div_by_zero", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", done, 0);
    issue(1'b0, 50, 5, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 0;
        1: begin b = $urandom | 1; a = a % b; end
        2, 3: b = $urandom_range(1, 1000);
        default: b = $urandom;
      endcase
      issue(1'b0, a, b, 0, 1'b0);
    end

    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 255);
      b = (i == 3) ? 0 : $urandom_range(0, 255);
      issue(1'b1, a, b, 0, 1'b0);
    end
    issue(1'b1, 255, 1, 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb32_drained", u64'(sb32.size()), 0);
    chk("sb8_drained", u64'(sb8.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring unsigned integer divider, N-bit dividend by N-bit divisor, producing N-bit quotient and N-bit remainder. It is the inverse-direction companion to the FP multiplier datapath: the FP divider path uses it for the mantissa quotient. It also serves as a standalone integer divide unit. Operands are captured on a start handshake, one quotient bit is resolved per enabled cycle, and results are held registered until the next operation.

## Interface
- N, 32, operand/result width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (block in reset while 0)
- en  input  1  clock enable; when 0 all internal state and outputs hold
- start  input  1  request; sampled only in IDLE with en=1
- dividend  input  N  unsigned dividend, captured with start
- divisor  input  N  unsigned divisor, captured with start
- busy  output  1  high from the cycle after acceptance until done asserts
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  N  registered quotient, held until next acceptance
- remainder  output  N  registered remainder, held until next acceptance
- div_by_zero  output  1  registered flag for the last completed operation

## Operation
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - On start=1 and en=1, latch dividend into the shift register Q and divisor into D.
  - Clear partial remainder R (N+1 bits) and set counter cnt=N-1.
  - Go to CALC; if divisor==0, go straight to FINISH with dz set.
- CALC, per enabled cycle:
  - {R,Q} shifted left one bit.
  - trial = R_shifted − {1'b0,D}.
  - If trial is non-negative, R=trial and Q[0]=1; else R is restored and Q[0]=0.
  - cnt decrements; when cnt==0 at the step edge, go to FINISH.
- FINISH (one cycle):
  - Transfer Q→quotient, R[N-1:0]→remainder, dz→div_by_zero.
  - Pulse done and return to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
- Arithmetic invariant for divisor≠0: dividend == quotient*divisor + remainder, with remainder < divisor.
- start while busy (CALC/FINISH) is ignored, not queued.
- en=0 in any state freezes FSM, counter, datapath and outputs. A done pulse stalled this way stays high until the next enabled edge.
- The reset value of every output is 0: busy, done, quotient, remainder and div_by_zero. The FSM resets to IDLE. Reset mid-operation abandons the operation with no done.

## Timing
- Acceptance edge is T0 (start=1 in IDLE, en=1).
- busy=1 from T0 through the step edges; CALC occupies N enabled edges, T1..TN.
- done=1 and results valid after edge TN+1, for one enabled cycle. Latency is N+1 enabled cycles; busy=0 while done=1.
- Divide by zero: done after edge T1, for a latency of 1.
- A new start may be accepted in the same cycle done is high, because the FSM is then in IDLE. Back-to-back throughput is one op per N+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- DIV_EARLY_EXIT_EN
  - Defined: in IDLE, if divisor≠0 and dividend<divisor, go straight to FINISH with quotient=0 and remainder=dividend. Latency is 1, the same as divide by zero.
  - Undefined: such operands take the full N+1 cycles; results are identical.

## Structure
- Package div_pkg holds:
  - the state enum div_state_t {IDLE, CALC, FINISH};
  - the default width constant DIV_W_DEFAULT=32;
  - the divide-by-zero quotient constant (all ones).
- One sub-module, div_step: purely combinational restoring step. Inputs are R, Q and D; outputs are the next R and next Q. It is instantiated once in the iterative datapath.

## Test plan
- 100/7, N=32 → done after 33 cycles; quotient=14, remainder=2, div_by_zero=0.
- 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0. Then 5/0 → done after 1 cycle, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- 3/10 → quotient=0, remainder=3. Latency is 1 cycle with DIV_EARLY_EXIT_EN, 33 cycles without.
- Hold en=0 for 5 cycles mid-CALC of 1000/3 → done delayed by exactly 5 cycles; quotient=333, remainder=1. Pulse start during CALC → ignored, single done.
- Assert reset low at cycle 10 of 50/5 → all outputs 0 asynchronously and no done. After release, 50/5 → quotient=10, remainder=0.
- Random operands for N=8 and N=32, back-to-back starts coincident with done → each result checked against the invariant.
